// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised register file with NRD registered read ports and one write
//   port. It provides an optional architectural zero register and optional
//   write-to-read bypass. After every reset, a clear sequencer writes zero to
//   each entry. The block accepts accesses only after that sequence finishes.
//
// Parameters
//   WIDTH    data width in bits
//   DEPTH    number of registers (need not be a power of two)
//   NRD      number of read ports (1..4)
//   ZERO_R0  register 0 reads as zero and ignores writes
//   BYPASS   forward a same-edge write to a read of the same register
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   ready    high once the clear sequence has finished
//   we       write enable
//   waddr    write address
//   wdata    write data
//   re       per-port read enable
//   raddr    read addresses, port p at [p*AW +: AW]
//   rdata    registered read data, port p at [p*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ready,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [NRD-1:0]       re,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  // The extra bit keeps the range check meaningful when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t           state, state_next;
  logic [AW-1:0]    clr_idx;

  logic             wr_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Sequencer: state register, next-state logic, output decode
  // ---------------------------------------------------------------------------
  // NOTE: use non-blocking (<=) assignments for all clocked state. This lets
  // every flop sample the pre-edge values, whatever the order of the processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_next;
      if (state == S_CLEAR && clr_idx != LAST_IDX)
        clr_idx <= clr_idx + AW'(1);
    end
  end

  // NOTE: give every always_comb output a default first. Otherwise a path
  // that leaves the output unassigned infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (clr_idx == LAST_IDX) state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_CLEAR;
    endcase
  end

  // ready is a pure decode of the state flop, so no input reaches it combinationally.
  always_comb begin
    ready = (state == S_RUN);
  end

  // ---------------------------------------------------------------------------
  // Write port. Clear writes and user writes share the single storage write
  // port. Any replicated copy of the array would therefore see identical writes.
  // ---------------------------------------------------------------------------
  assign wr_en = (state == S_RUN) && we
               && ({1'b0, waddr} < DEPTH_W)
               && !(ZERO_R0 && waddr == '0);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = waddr;
    mem_wdata = wdata;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_idx;
      mem_wdata = '0;
    end else if (wr_en) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array is deliberately left out of reset. A reset would rule out
  // RAM inference, and the clear sequencer gives defined contents instead.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]    addr;
    logic             addr_ok;
    logic             zero_hit;
    logic             fwd_hit;
    logic [WIDTH-1:0] rd_next;
    logic [WIDTH-1:0] rd_q;

    assign addr     = raddr[p*AW +: AW];
    assign addr_ok  = ({1'b0, addr} < DEPTH_W);
    assign zero_hit = ZERO_R0 && (addr == '0);
    // wr_en already excludes dropped writes, so out-of-range targets and r0 never forward.
    assign fwd_hit  = BYPASS && wr_en && (waddr == addr);

    always_comb begin
      rd_next = mem[addr];
      if (!addr_ok || zero_hit)
        rd_next = '0;
      else if (fwd_hit)
        rd_next = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        rd_q <= '0;
      else if (state == S_RUN && re[p])
        rd_q <= rd_next;
    end

    assign rdata[p*WIDTH +: WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Directed bench for regfile_mp. Four builds run side by side:
//     u_def : defaults (32x32, 2 ports, zero register, bypass)
//     u_nz  : ZERO_R0=0
//     u_nb  : BYPASS=0
//     u_np  : WIDTH=16, DEPTH=24, NRD=3 (non-power-of-two depth)
//   The three 32-deep builds share one stimulus bus. The 24-deep build has its own bus.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  // Shared stimulus for the 32-deep builds
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;

  logic        ready_def, ready_nz, ready_nb;
  logic [63:0] rd_def, rd_nz, rd_nb;

  // Stimulus for the 16x24x3 build (AW = 5)
  logic        we3;
  logic [4:0]  waddr3;
  logic [15:0] wdata3;
  logic [2:0]  re3;
  logic [14:0] raddr3;
  logic        ready_np;
  logic [47:0] rd_np;

  int checks = 0;
  int errors = 0;

  regfile_mp u_def (
    .clk(clk), .rst_n(rst_n), .ready(ready_def), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rd_def)
  );

  regfile_mp #(.ZERO_R0(1'b0)) u_nz (
    .clk(clk), .rst_n(rst_n), .ready(ready_nz), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rd_nz)
  );

  regfile_mp #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .ready(ready_nb), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rd_nb)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(24), .NRD(3)) u_np (
    .clk(clk), .rst_n(rst_n), .ready(ready_np), .we(we3), .waddr(waddr3),
    .wdata(wdata3), .re(re3), .raddr(raddr3), .rdata(rd_np)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit so outputs are sampled clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    we     = 1'b0; waddr  = '0; wdata  = '0; re  = '0; raddr  = '0;
    we3    = 1'b0; waddr3 = '0; wdata3 = '0; re3 = '0; raddr3 = '0;

    // ---------------- reset held for 3 cycles ----------------
    repeat (3) tick();
    check("rst_ready_def", 64'(ready_def), 64'd0);
    check("rst_rdata_def", rd_def,         64'd0);
    check("rst_ready_np",  64'(ready_np),  64'd0);
    check("rst_rdata_np",  64'(rd_np),     64'd0);

    // ---------------- clear timing ----------------
    rst_n = 1'b1;
    re    = 2'b11;
    raddr = {5'd5, 5'd5};
    for (int i = 1; i <= 32; i++) begin
      if (i == 20) begin
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      end
      tick();
      we = 1'b0;
      if (i == 21) check("clear_rdata_held", rd_def, 64'd0);
      if (i == 23) check("np_ready_early", 64'(ready_np), 64'd0);
      if (i == 24) check("np_ready_on_time", 64'(ready_np), 64'd1);
      if (i == 31) check("ready_early", 64'(ready_def), 64'd0);
      if (i == 32) check("ready_on_time", 64'(ready_def), 64'd1);
    end
    check("clear_rdata_last", rd_def, 64'd0);

    // The write to r5 during clear must have been dropped.
    re = 2'b11; raddr = {5'd5, 5'd5};
    tick();
    check("r5_after_clear", rd_def, 64'd0);

    // ---------------- basic access ----------------
    re = 2'b00;
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    tick();
    we = 1'b0;
    re = 2'b11; raddr = {5'd7, 5'd7};
    tick();
    check("r7_both_ports", rd_def, {32'h12345678, 32'h12345678});
    re = 2'b00; raddr = {5'd5, 5'd5};
    tick();
    check("r7_hold", rd_def, {32'h12345678, 32'h12345678});

    // ---------------- zero register ----------------
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    tick();
    we = 1'b0;
    re = 2'b01; raddr = {5'd7, 5'd0};
    tick();
    check("r0_zero_def", rd_def, {32'h12345678, 32'h00000000});
    check("r0_plain_nz", {32'h0, rd_nz[31:0]}, 64'hFFFFFFFF);
    // A same-edge write to r0 must not reach the zero register, even through the bypass.
    we = 1'b1; waddr = 5'd0; wdata = 32'h00000055;
    re = 2'b01; raddr = {5'd0, 5'd0};
    tick();
    we = 1'b0;
    check("r0_bypass_def", {32'h0, rd_def[31:0]}, 64'h0);
    check("r0_bypass_nz",  {32'h0, rd_nz[31:0]},  64'h55);

    // ---------------- bypass ----------------
    re = 2'b00;
    we = 1'b1; waddr = 5'd3; wdata = 32'h00000011;
    tick();
    we = 1'b1; waddr = 5'd3; wdata = 32'h00000022;
    re = 2'b11; raddr = {5'd3, 5'd3};
    tick();
    we = 1'b0;
    check("bypass_on",  rd_def, {32'h22, 32'h22});
    check("bypass_off", rd_nb,  {32'h11, 32'h11});
    tick();
    check("after_bypass_def", rd_def, {32'h22, 32'h22});
    check("after_bypass_nb",  rd_nb,  {32'h22, 32'h22});

    // ---------------- non-power-of-two depth ----------------
    we3 = 1'b1; waddr3 = 5'd23; wdata3 = 16'hBEEF;
    tick();
    we3 = 1'b1; waddr3 = 5'd30; wdata3 = 16'h1234;
    re3 = 3'b010; raddr3 = {5'd0, 5'd30, 5'd0};
    tick();
    we3 = 1'b0;
    check("np_oob_same_edge", 64'(rd_np[31:16]), 64'h0);
    re3 = 3'b111; raddr3 = {5'd14, 5'd30, 5'd23};
    tick();
    check("np_r23_r30_r14", 64'(rd_np), {16'h0, 16'h0000, 16'h0000, 16'hBEEF});
    raddr3 = {5'd6, 5'd23, 5'd23};
    tick();
    check("np_r23x2_r6", 64'(rd_np), {16'h0, 16'h0000, 16'hBEEF, 16'hBEEF});

    // ---------------- reset mid-operation ----------------
    re3 = 3'b000;
    re = 2'b00;
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
    tick();
    we = 1'b0;
    re = 2'b11; raddr = {5'd9, 5'd9};
    tick();
    check("r9_written", rd_def, {32'hA5A5A5A5, 32'hA5A5A5A5});
    re = 2'b00;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_rdata", rd_def, 64'd0);
    check("midrun_rst_ready", 64'(ready_def), 64'd0);
    check("midrun_rst_np",    64'(rd_np),     64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 31) check("rerst_ready_early", 64'(ready_def), 64'd0);
      if (i == 32) check("rerst_ready_on_time", 64'(ready_def), 64'd1);
    end
    re = 2'b11; raddr = {5'd9, 5'd7};
    tick();
    check("r9_r7_cleared", rd_def, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; successor to the fixed 32x32, 2-read-port regfile.
- Generalised in width, depth and read-port count.
- Adds an architectural zero register, write-to-read bypass, and a hardware clear sequencer that zeroes the array after reset.
- Sits between decode and execute; feeds operand latches, written from writeback.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- DEPTH, 32, number of registers (>=2, need not be a power of two).
- NRD, 2, number of read ports (1..4).
- ZERO_R0, 1, when 1, register 0 reads as zero and writes to it are dropped.
- BYPASS, 1, when 1, a same-cycle write to a register being read is forwarded to the read data.
- Derived localparam AW = clog2(DEPTH), address width.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ready  out  1  high once the clear sequence has finished; accesses are accepted only while high.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- re  in  NRD  per-port read enable.
- raddr  in  NRD*AW  read addresses; port p occupies [p*AW +: AW].
- rdata  out  NRD*WIDTH  registered read data; port p occupies [p*WIDTH +: WIDTH].

Behaviour:
- Reset (rst_n low, async):
  - ready=0, all rdata=0, FSM=CLEAR, clear index=0.
  - Array contents are not touched asynchronously.
- FSM states: CLEAR, RUN.
  - CLEAR: each rising edge writes 0 to array[clear index], then increments the index.
  - When index==DEPTH-1 is written, move to RUN; ready=1 from the next cycle.
  - CLEAR takes exactly DEPTH cycles after rst_n rises.
  - In CLEAR, we and re are ignored and rdata holds 0.
  - RUN: stays until reset; no other exit.
- Write (RUN only):
  - array[waddr] <= wdata at the rising edge where we=1.
  - Dropped if ZERO_R0=1 and waddr==0.
  - Dropped if waddr >= DEPTH.
- Read (RUN only):
  - 1-cycle latency: on an edge with re[p]=1, rdata[p] loads the value at raddr[p].
  - With re[p]=0, rdata[p] holds its previous value.
  - raddr[p] >= DEPTH loads 0.
  - ZERO_R0=1 and raddr[p]==0 loads 0, regardless of any write or bypass.
- Same-edge read and write to the same address, write not dropped:
  - BYPASS=1: rdata[p] loads wdata.
  - BYPASS=0: rdata[p] loads the pre-write contents.
  - The write itself always completes.
- Multiple ports may read the same address on the same edge; all return the same value.
- Reset mid-CLEAR or mid-RUN: restarts CLEAR from index 0; the full DEPTH-cycle clear repeats.
- No combinational path from any input to rdata or ready.
- Storage: flop or inferred-RAM array.
  - NRD read ports may be implemented by replicating the array, one copy per port, all written together.
  - Replicated copies must remain identical under every write, including clear writes.

Test Plan:
- Clear timing: defaults; rst_n low 3 cycles then high -> ready rises exactly 32 cycles later. A pulse of we=1, waddr=5, wdata=0xDEADBEEF during CLEAR is ignored; reading r5 after ready returns 0.
- Basic access: write r7=0x12345678, then the next cycle read r7 on port 0 and r7 on port 1 -> both rdata=0x12345678 one cycle after the read edge. Hold re=0 -> rdata unchanged.
- Zero register: write r0=0xFFFFFFFF with ZERO_R0=1 -> r0 reads 0. Rebuild with ZERO_R0=0 -> r0 reads 0xFFFFFFFF.
- Bypass: r3 holds 0x11; same edge we=1 waddr=3 wdata=0x22 with port 0 reading r3 -> rdata[0]=0x22 (BYPASS=1) or 0x11 (BYPASS=0). The next read of r3 returns 0x22 in both builds.
- Non-power-of-two range: WIDTH=16, DEPTH=24, NRD=3. Writes to r23 and r30 -> r23 readable. The r30 write is dropped and no register is aliased: r30 and r14 both read 0.
- Reset mid-operation: after writing r9=0xA5A5A5A5 in RUN, assert rst_n for 1 cycle -> rdata=0 immediately, ready=0. After a further DEPTH cycles ready=1 and r9 reads 0.
